fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_VEC, default 32'h80000000, meaning PC after reset.
REQ-002 Parameter IRQ_VEC, default 32'h80000004, meaning interrupt entry PC.
REQ-003 Parameter EXC_VEC, default 32'h80000008, meaning undefined-instruction exception entry PC.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 stall  input  1  load-use hazard; hold PC.
REQ-007 redirect_valid  input  1  branch/jump/jr resolved in ID stage this cycle.
REQ-008 redirect_pc  input  32  target for redirect_valid.
REQ-009 irq  input  1  level interrupt request from timer.
REQ-010 exception  input  1  undefined instruction detected in ID this cycle.
REQ-011 exc_pc  input  32  PC of the instruction in ID.
REQ-012 pc  output  32  instruction memory address.
REQ-013 fetch_valid  output  1  pc carries a real fetch this cycle.
REQ-014 flush_if  output  1  clear IF/ID register at next edge.
REQ-015 flush_id  output  1  clear ID/EX register at next edge.
REQ-016 epc  output  32  resume address captured on vector entry.
REQ-017 kernel  output  1  kernel mode flag.

Function
REQ-018 States SHALL be BOOT, RUN, VECTOR; BOOT->RUN unconditionally; VECTOR->RUN unconditionally; RUN->VECTOR on accepted irq or exception.
REQ-019 BOOT: fetch_valid=0, pc=RESET_VEC, flushes 0, all inputs ignored; the following RUN cycle SHALL fetch RESET_VEC (no increment in BOOT).
REQ-020 RUN next-PC priority SHALL be: exception > accepted irq > redirect_valid > stall > increment.
REQ-021 Increment SHALL be pc <= {pc[31], pc[30:0]+4}; bit 31 preserved; pc[30:0] wraps 7FFFFFFC->00000000 silently.
REQ-022 Redirect SHALL load redirect_pc even when stall=1 (redirect overrides stall); stall alone holds pc unchanged.
REQ-023 Exception in RUN: pc <= EXC_VEC, epc <= exc_pc+4 (32-bit wrap), kernel <= 1, flush_if=1 and flush_id=1 combinationally that cycle; accepted regardless of kernel.
REQ-024 irq accepted in RUN only when irq=1, kernel=0, exception=0, stall=0; then pc <= IRQ_VEC, kernel <= 1, flush_if=1, flush_id=0, epc <= redirect_valid ? redirect_pc : pc.
REQ-025 irq while kernel=1 or stall=1 SHALL be ignored (no latching); a held level is accepted the first eligible cycle.
REQ-026 kernel SHALL clear when a redirect is taken in RUN with redirect_pc[31]=0 (kernel return); redirect with redirect_pc[31]=1 leaves kernel unchanged.
REQ-027 Redirect with no vector entry SHALL assert flush_if=1 that cycle (kill delay-slot fetch), flush_id=0.
REQ-028 VECTOR (one cycle): pc=vector address, fetch_valid=1, flushes 0; irq, exception, redirect_valid ignored (originate from flushed instruction); stall honoured (holds pc, stays one cycle only, then RUN still holds pc while stall=1).
REQ-029 fetch_valid SHALL be 1 in RUN and VECTOR, 0 in BOOT.
REQ-030 epc SHALL change only on vector entry.

Reset
REQ-031 reset=0 SHALL immediately force state=BOOT, pc=RESET_VEC, epc=0, kernel=1, fetch_valid=0, flush_if=0, flush_id=0, independent of clk.
REQ-032 Reset asserted mid-vector or mid-stall SHALL discard all pending activity; no irq memory survives reset.

Verification
REQ-033 Release reset, no stimulus -> pc 80000000 (fetch_valid 0), 80000000, 80000004, 80000008 on successive cycles, kernel=1.
REQ-034 Redirect to 00000000 in RUN -> kernel 0, flush_if 1 that cycle; next pcs 00000000, 00000004; stall=1 for 2 cycles at 00000004 -> pc held two cycles.
REQ-035 kernel=0, pc=00000040, irq=1 -> flush_if 1, flush_id 0; next pc 80000004, epc 00000040, kernel 1; irq held high -> no second entry until redirect to 00000040 clears kernel, then entry next eligible cycle.
REQ-036 Same cycle exception (exc_pc 0000003C) and irq with redirect_valid -> exception wins: pc 80000008, epc 00000040, flush_if=flush_id=1.
REQ-037 kernel=0, irq=1, stall=1, redirect_valid=1 to 00000100 -> irq not taken, pc 00000100; irq taken following cycle with epc=pc.
REQ-038 Drive reset low while in VECTOR -> outputs at reset values asynchronously; after release, BOOT sequence per REQ-033.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: pipeline-side control inputs and fetch/vector outputs of the sequencer
interface fetch_sequencer_if;
    logic        stall, redirect_valid, irq, exception;
    logic [31:0] redirect_pc, exc_pc;
    logic        fetch_valid, flush_if, flush_id, kernel;
    logic [31:0] pc, epc;
    modport master (
        input  stall, redirect_valid, redirect_pc, irq, exception, exc_pc,
        output pc, fetch_valid, flush_if, flush_id, epc, kernel
    );
    modport slave (
        output stall, redirect_valid, redirect_pc, irq, exception, exc_pc,
        input  pc, fetch_valid, flush_if, flush_id, epc, kernel
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: next-PC selection with redirect, stall, interrupt and exception vectoring
module fetch_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h80000000,
    parameter logic [31:0] IRQ_VEC   = 32'h80000004,
    parameter logic [31:0] EXC_VEC   = 32'h80000008
) (
    input logic              clk,
    input logic              reset,
    fetch_sequencer_if.master bus
);
    typedef enum logic [1:0] {BOOT, RUN, VECTOR} state_t;
    state_t      state;
    logic        run, irq_take;
    logic [31:0] pc_inc;
    assign run      = state == RUN;
    assign irq_take = run && bus.irq && !bus.kernel && !bus.exception && !bus.stall;
    // bit 31 selects the kernel region and is never carried into
    assign pc_inc      = {bus.pc[31], bus.pc[30:0] + 31'd4};
    assign bus.flush_if = run && (bus.exception || irq_take || bus.redirect_valid);
    assign bus.flush_id = run && bus.exception;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= BOOT;
            bus.pc          <= RESET_VEC;
            bus.epc         <= 32'h0;
            bus.kernel      <= 1'b1;
            bus.fetch_valid <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state           <= RUN;
                    bus.fetch_valid <= 1'b1;
                end
                VECTOR: begin
                    state <= RUN;
                    if (!bus.stall) bus.pc <= pc_inc;
                end
                default: begin
                    if (bus.exception) begin
                        state      <= VECTOR;
                        bus.pc     <= EXC_VEC;
                        bus.epc    <= bus.exc_pc + 32'd4;
                        bus.kernel <= 1'b1;
                    end else if (irq_take) begin
                        state      <= VECTOR;
                        bus.pc     <= IRQ_VEC;
                        bus.epc    <= bus.redirect_valid ? bus.redirect_pc : bus.pc;
                        bus.kernel <= 1'b1;
                    end else if (bus.redirect_valid) begin
                        bus.pc <= bus.redirect_pc;
                        if (!bus.redirect_pc[31]) bus.kernel <= 1'b0;
                    end else if (!bus.stall) begin
                        bus.pc <= pc_inc;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios with hand-computed PC/EPC/kernel/flush expectations
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;
    fetch_sequencer_if bus ();
    fetch_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic idle();
        bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
        bus.irq = 0; bus.exception = 0; bus.exc_pc = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] a);
        bus.redirect_valid = 1; bus.redirect_pc = a;
        tick();
        bus.redirect_valid = 0;
    endtask

    task automatic test_reset();
        idle();
        #12;
        total++; if (bus.pc !== 32'h80000000) begin bad++; $display("FAIL rst_pc got=%h exp=80000000", bus.pc); end
        total++; if (bus.epc !== 32'h0) begin bad++; $display("FAIL rst_epc got=%h exp=00000000", bus.epc); end
        total++; if ({bus.kernel, bus.fetch_valid, bus.flush_if, bus.flush_id} !== 4'b1000) begin bad++; $display("FAIL rst_flags got=%b exp=1000", {bus.kernel, bus.fetch_valid, bus.flush_if, bus.flush_id}); end
        @(negedge clk);
        reset = 1;
        #1;
        total++; if (bus.fetch_valid !== 1'b0 || bus.pc !== 32'h80000000) begin bad++; $display("FAIL boot got fv=%b pc=%h exp fv=0 pc=80000000", bus.fetch_valid, bus.pc); end
        tick();
        total++; if (bus.fetch_valid !== 1'b1 || bus.pc !== 32'h80000000) begin bad++; $display("FAIL run0 got fv=%b pc=%h exp fv=1 pc=80000000", bus.fetch_valid, bus.pc); end
        tick();
        total++; if (bus.pc !== 32'h80000004) begin bad++; $display("FAIL run1_pc got=%h exp=80000004", bus.pc); end
        tick();
        total++; if (bus.pc !== 32'h80000008 || bus.kernel !== 1'b1) begin bad++; $display("FAIL run2 got pc=%h k=%b exp pc=80000008 k=1", bus.pc, bus.kernel); end
    endtask

    task automatic test_redirect();
        bus.redirect_valid = 1; bus.redirect_pc = 32'h0;
        #1;
        total++; if (bus.flush_if !== 1'b1 || bus.flush_id !== 1'b0) begin bad++; $display("FAIL redir_flush got if=%b id=%b exp if=1 id=0", bus.flush_if, bus.flush_id); end
        tick();
        bus.redirect_valid = 0;
        total++; if (bus.pc !== 32'h0 || bus.kernel !== 1'b0) begin bad++; $display("FAIL redir_pc got pc=%h k=%b exp pc=00000000 k=0", bus.pc, bus.kernel); end
        tick();
        total++; if (bus.pc !== 32'h4) begin bad++; $display("FAIL redir_inc got=%h exp=00000004", bus.pc); end
        bus.stall = 1;
        tick();
        total++; if (bus.pc !== 32'h4) begin bad++; $display("FAIL stall1 got=%h exp=00000004", bus.pc); end
        tick();
        total++; if (bus.pc !== 32'h4 || bus.flush_if !== 1'b0) begin bad++; $display("FAIL stall2 got pc=%h fi=%b exp pc=00000004 fi=0", bus.pc, bus.flush_if); end
        bus.stall = 0;
        tick();
        total++; if (bus.pc !== 32'h8) begin bad++; $display("FAIL unstall got=%h exp=00000008", bus.pc); end
    endtask

    task automatic test_irq();
        redirect_to(32'h40);
        bus.irq = 1;
        #1;
        total++; if (bus.flush_if !== 1'b1 || bus.flush_id !== 1'b0) begin bad++; $display("FAIL irq_flush got if=%b id=%b exp if=1 id=0", bus.flush_if, bus.flush_id); end
        tick();
        total++; if (bus.pc !== 32'h80000004 || bus.epc !== 32'h40 || bus.kernel !== 1'b1) begin bad++; $display("FAIL irq_entry got pc=%h epc=%h k=%b exp 80000004 00000040 1", bus.pc, bus.epc, bus.kernel); end
        tick();
        total++; if (bus.pc !== 32'h80000008 || bus.flush_if !== 1'b0) begin bad++; $display("FAIL irq_kmask got pc=%h fi=%b exp pc=80000008 fi=0", bus.pc, bus.flush_if); end
        tick();
        total++; if (bus.pc !== 32'h8000000c) begin bad++; $display("FAIL irq_kmask2 got=%h exp=8000000c", bus.pc); end
        redirect_to(32'h40);
        total++; if (bus.pc !== 32'h40 || bus.kernel !== 1'b0 || bus.flush_if !== 1'b1) begin bad++; $display("FAIL irq_ret got pc=%h k=%b fi=%b exp 00000040 0 1", bus.pc, bus.kernel, bus.flush_if); end
        tick();
        bus.irq = 0;
        total++; if (bus.pc !== 32'h80000004 || bus.epc !== 32'h40) begin bad++; $display("FAIL irq_reentry got pc=%h epc=%h exp 80000004 00000040", bus.pc, bus.epc); end
        tick();
    endtask

    task automatic test_exception();
        redirect_to(32'h40);
        bus.exception = 1; bus.exc_pc = 32'h3c; bus.irq = 1;
        bus.redirect_valid = 1; bus.redirect_pc = 32'h200;
        #1;
        total++; if (bus.flush_if !== 1'b1 || bus.flush_id !== 1'b1) begin bad++; $display("FAIL exc_flush got if=%b id=%b exp 1 1", bus.flush_if, bus.flush_id); end
        tick();
        bus.exc_pc = 32'h500; bus.redirect_pc = 32'h0;
        total++; if (bus.pc !== 32'h80000008 || bus.epc !== 32'h40 || bus.kernel !== 1'b1) begin bad++; $display("FAIL exc_entry got pc=%h epc=%h k=%b exp 80000008 00000040 1", bus.pc, bus.epc, bus.kernel); end
        total++; if (bus.flush_if !== 1'b0 || bus.flush_id !== 1'b0) begin bad++; $display("FAIL vec_flush got if=%b id=%b exp 0 0", bus.flush_if, bus.flush_id); end
        tick();
        idle();
        total++; if (bus.pc !== 32'h8000000c || bus.epc !== 32'h40 || bus.kernel !== 1'b1) begin bad++; $display("FAIL vec_ignore got pc=%h epc=%h k=%b exp 8000000c 00000040 1", bus.pc, bus.epc, bus.kernel); end
    endtask

    task automatic test_stall_redirect();
        redirect_to(32'h80);
        bus.irq = 1; bus.stall = 1; bus.redirect_valid = 1; bus.redirect_pc = 32'h100;
        #1;
        total++; if (bus.flush_if !== 1'b1 || bus.flush_id !== 1'b0) begin bad++; $display("FAIL sr_flush got if=%b id=%b exp 1 0", bus.flush_if, bus.flush_id); end
        tick();
        bus.stall = 0; bus.redirect_valid = 0;
        total++; if (bus.pc !== 32'h100 || bus.kernel !== 1'b0 || bus.epc !== 32'h40) begin bad++; $display("FAIL sr_redir got pc=%h k=%b epc=%h exp 00000100 0 00000040", bus.pc, bus.kernel, bus.epc); end
        tick();
        bus.irq = 0;
        total++; if (bus.pc !== 32'h80000004 || bus.epc !== 32'h100) begin bad++; $display("FAIL sr_irq got pc=%h epc=%h exp 80000004 00000100", bus.pc, bus.epc); end
        tick();
    endtask

    task automatic test_wrap();
        redirect_to(32'h7ffffffc);
        tick();
        total++; if (bus.pc !== 32'h0) begin bad++; $display("FAIL wrap_low got=%h exp=00000000", bus.pc); end
        redirect_to(32'hfffffffc);
        total++; if (bus.pc !== 32'hfffffffc || bus.kernel !== 1'b0) begin bad++; $display("FAIL hi_redir got pc=%h k=%b exp fffffffc 0", bus.pc, bus.kernel); end
        tick();
        total++; if (bus.pc !== 32'h80000000) begin bad++; $display("FAIL wrap_high got=%h exp=80000000", bus.pc); end
    endtask

    task automatic test_vector_stall();
        bus.exception = 1; bus.exc_pc = 32'hfffffffc;
        tick();
        bus.exception = 0;
        total++; if (bus.pc !== 32'h80000008 || bus.epc !== 32'h0 || bus.kernel !== 1'b1) begin bad++; $display("FAIL epc_wrap got pc=%h epc=%h k=%b exp 80000008 00000000 1", bus.pc, bus.epc, bus.kernel); end
        bus.stall = 1;
        tick();
        total++; if (bus.pc !== 32'h80000008) begin bad++; $display("FAIL vstall1 got=%h exp=80000008", bus.pc); end
        tick();
        total++; if (bus.pc !== 32'h80000008 || bus.fetch_valid !== 1'b1) begin bad++; $display("FAIL vstall2 got pc=%h fv=%b exp 80000008 1", bus.pc, bus.fetch_valid); end
        bus.stall = 0;
        tick();
        total++; if (bus.pc !== 32'h8000000c) begin bad++; $display("FAIL vstall_rel got=%h exp=8000000c", bus.pc); end
    endtask

    task automatic test_reset_mid_vector();
        bus.exception = 1; bus.exc_pc = 32'h10;
        tick();
        bus.irq = 1;
        total++; if (bus.epc !== 32'h14 || bus.pc !== 32'h80000008) begin bad++; $display("FAIL pre_rst got pc=%h epc=%h exp 80000008 00000014", bus.pc, bus.epc); end
        #2;
        reset = 0;
        #1;
        total++; if (bus.pc !== 32'h80000000 || bus.epc !== 32'h0) begin bad++; $display("FAIL async_rst got pc=%h epc=%h exp 80000000 00000000", bus.pc, bus.epc); end
        total++; if ({bus.kernel, bus.fetch_valid, bus.flush_if, bus.flush_id} !== 4'b1000) begin bad++; $display("FAIL async_flags got=%b exp=1000", {bus.kernel, bus.fetch_valid, bus.flush_if, bus.flush_id}); end
        @(negedge clk);
        reset = 1;
        #1;
        total++; if (bus.fetch_valid !== 1'b0 || bus.flush_if !== 1'b0 || bus.flush_id !== 1'b0) begin bad++; $display("FAIL boot_ignore got fv=%b if=%b id=%b exp 0 0 0", bus.fetch_valid, bus.flush_if, bus.flush_id); end
        tick();
        idle();
        total++; if (bus.pc !== 32'h80000000 || bus.fetch_valid !== 1'b1) begin bad++; $display("FAIL reboot0 got pc=%h fv=%b exp 80000000 1", bus.pc, bus.fetch_valid); end
        tick();
        total++; if (bus.pc !== 32'h80000004 || bus.kernel !== 1'b1 || bus.epc !== 32'h0) begin bad++; $display("FAIL reboot1 got pc=%h k=%b epc=%h exp 80000004 1 00000000", bus.pc, bus.kernel, bus.epc); end
    endtask

    initial begin
        test_reset();
        test_redirect();
        test_irq();
        test_exception();
        test_stall_redirect();
        test_wrap();
        test_vector_stall();
        test_reset_mid_vector();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
